// File: rtl/uart_tx_fem.sv
// rtl/uart_tx_fem.sv - 8N1 UART transmitter with a byte FIFO, back-to-back framing
// The FIFO pops straight into the shift register, so STOP can chain into START with no idle gap.

module uart_tx_fem #(
  parameter int CLKS_PER_BIT = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_fem
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          fem_n;
  logic          baud_done;

  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign tx_ready = !full;
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign tx_busy  = (state != IDLE) || !empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_fem  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_fem  <= fem_n;
    end
  end

  assign baud_done = (cnt == BAUD_LAST);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    fem_n     = tx_fem;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          state_n = START;
          pop     = 1'b1;
          shift_n = head;
          fem_n   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
          fem_n     = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            fem_n   = 1'b1;
          end else begin
            shift_n   = shift >> 1;
            fem_n     = shift[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_n = '0;
          if (!empty) begin
            state_n = START;
            pop     = 1'b1;
            shift_n = head;
            fem_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        fem_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fem.sv
// tb/tb_uart_tx_fem.sv - directed self-checking bench for uart_tx_fem
// Two instances: default parameters, and CLKS_PER_BIT=2 / FIFO_DEPTH=2.

module tb_uart_tx_fem;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_fem;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       tx_busy2;
  logic       tx_fem2;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk_in = ~clk_in;

  uart_tx_fem #(.CLKS_PER_BIT(64), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_fem(tx_fem)
  );

  uart_tx_fem #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut2 (
    .clk_in(clk_in), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_busy(tx_busy2), .tx_fem(tx_fem2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Entered just after the edge that drove the start bit (plus off cycles already spent in it);
  // returns just after the edge that ends the stop bit.
  task automatic check_frame(input int sel, input int cpb, input logic [7:0] b, input int off,
                             input string tag);
    logic exp;
    logic line;
    int   bad;
    for (int i = 0; i < 10; i++) begin
      exp = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      bad = 0;
      for (int c = ((i == 0) ? off : 0); c < cpb; c++) begin
        line = (sel != 0) ? tx_fem2 : tx_fem;
        if (line !== exp) bad++;
        tick();
      end
      check_eq($sformatf("%s_bit%0d_badcycles", tag, i), bad, 0);
    end
  endtask

  initial begin
    int bad;
    reset     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;
    tick();
    tick();
    check_eq("rst_fem", tx_fem, 1);
    check_eq("rst_ready", tx_ready, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_fem2", tx_fem2, 1);
    check_eq("rst_ready2", tx_ready2, 1);
    reset = 1'b1;
    tick();

    // single byte
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick();
    tx_valid = 1'b0;
    check_eq("a5_prestart_fem", tx_fem, 1);
    check_eq("a5_prestart_busy", tx_busy, 1);
    tick();
    check_frame(0, 64, 8'hA5, 0, "a5");
    check_eq("a5_end_busy", tx_busy, 0);
    check_eq("a5_end_fem", tx_fem, 1);

    // back-to-back
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    tx_data = 8'hFF;
    tick();
    fork
      begin
        check_frame(0, 64, 8'h00, 0, "b2b_00");
        check_frame(0, 64, 8'hFF, 0, "b2b_ff");
        check_frame(0, 64, 8'h55, 0, "b2b_55");
      end
      begin
        tx_data = 8'h55;
        tick();
        tx_valid = 1'b0;
        check_eq("b2b_busy_mid", tx_busy, 1);
      end
    join
    check_eq("b2b_end_busy", tx_busy, 0);

    // full boundary, then refill and a push on the pop edge
    tx_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tx_data = 8'(i);
      tick();
    end
    fork
      begin
        check_frame(0, 64, 8'h01, 3, "full_01");
        check_frame(0, 64, 8'h02, 0, "full_02");
        check_frame(0, 64, 8'h03, 0, "full_03");
        check_frame(0, 64, 8'h04, 0, "full_04");
        check_frame(0, 64, 8'h05, 0, "full_05");
        check_frame(0, 64, 8'h06, 0, "full_06");
        check_frame(0, 64, 8'h77, 0, "full_77");
      end
      begin
        tx_data = 8'h06;
        check_eq("full_ready_06", tx_ready, 0);
        tick();
        tx_valid = 1'b0;
        repeat (635) tick();
        check_eq("full_ready_before_pop", tx_ready, 0);
        tick();
        check_eq("full_ready_after_pop", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h06;
        tick();
        tx_valid = 1'b0;
        check_eq("refull_ready", tx_ready, 0);
        repeat (638) tick();
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        check_eq("simul_ready_low", tx_ready, 0);
        tick();
        check_eq("simul_ready_freed", tx_ready, 1);
        tick();
        tx_valid = 1'b0;
        check_eq("simul_accepted_full", tx_ready, 0);
      end
    join
    check_eq("full_end_busy", tx_busy, 0);

    // reset mid-frame
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_data = 8'h11;
    tick();
    tx_data = 8'h22;
    tick();
    tx_valid = 1'b0;
    repeat (265) tick();
    check_eq("mid_bit3_level", tx_fem, 0);
    check_eq("mid_busy", tx_busy, 1);
    reset = 1'b0;
    tick();
    check_eq("mid_rst_fem", tx_fem, 1);
    check_eq("mid_rst_busy", tx_busy, 0);
    check_eq("mid_rst_ready", tx_ready, 1);
    reset = 1'b1;
    bad = 0;
    repeat (1400) begin
      tick();
      if (tx_fem !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check_eq("mid_no_resume_badcycles", bad, 0);

    // small parameter set
    tx_valid2 = 1'b1;
    tx_data2  = 8'hA5;
    tick();
    tx_valid2 = 1'b0;
    check_eq("p_prestart_fem", tx_fem2, 1);
    tick();
    check_frame(1, 2, 8'hA5, 0, "p_a5");
    check_eq("p_a5_end_busy", tx_busy2, 0);
    tx_valid2 = 1'b1;
    tx_data2  = 8'h3C;
    tick();
    check_eq("p_ready_1", tx_ready2, 1);
    tx_data2 = 8'h81;
    tick();
    check_eq("p_ready_2", tx_ready2, 1);
    tx_data2 = 8'h7E;
    tick();
    check_eq("p_full_ready", tx_ready2, 0);
    tx_valid2 = 1'b0;
    check_frame(1, 2, 8'h3C, 1, "p_3c");
    check_frame(1, 2, 8'h81, 0, "p_81");
    check_frame(1, 2, 8'h7E, 0, "p_7e");
    check_eq("p_end_busy", tx_busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
